serial_tx_lane: RTL and testbench

//  Single-clock serializer lane: parallel words in, one bit per clk out, MSB first, on a differential pair.

---
 rtl/serial_tx_lane.sv | 111 +++++++++++
 tb/tb_serial_tx_lane.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/serial_tx_lane.sv
// Serializer lane: parallel words in, one bit per clk out (MSB first) on a
// differential pair, with optional Manchester expansion of each byte to 16 bits.
module serial_tx_lane #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  oce,
  input  logic                  man_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  word_req,
  output logic                  serial_out,
  output logic                  serial_out_p,
  output logic                  serial_out_n
);

  localparam int unsigned      CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam bit               MAN_OK   = (DATA_WIDTH == 8);

  // PH_FIRST: next load takes a fresh data_in; PH_SECOND: next load drains hold
  typedef enum logic {
    PH_FIRST  = 1'b0,
    PH_SECOND = 1'b1
  } phase_e;

  phase_e                phase_q, phase_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-2:0] shreg_q, shreg_d;
  logic [7:0]            hold_q, hold_d;
  logic                  man_q, man_d;
  logic                  serial_q, serial_d;

  logic [7:0]            byte_in;
  logic [15:0]           man_code;
  logic [DATA_WIDTH-1:0] word;
  logic                  load_edge;

  // Each data bit becomes a two-bit symbol: 1 -> 01, 0 -> 10.
  always_comb begin
    byte_in = '0;
    byte_in[DATA_WIDTH-1:0] = data_in;
    man_code = '0;
    for (int i = 0; i < 8; i++) begin
      man_code[2*i+1] = ~byte_in[i];
      man_code[2*i]   = byte_in[i];
    end
  end

  always_comb begin
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    hold_d    = hold_q;
    man_d     = man_q;
    serial_d  = serial_q;
    word      = '0;
    load_edge = (bit_cnt_q == CNT_LAST);

    if (oce) begin
      bit_cnt_d = (bit_cnt_q == '0) ? CNT_LAST : bit_cnt_q - CNT_W'(1);
      if (load_edge) begin
        if (phase_q == PH_SECOND) begin
          word    = hold_q[7 -: DATA_WIDTH];
          phase_d = PH_FIRST;
        end else begin
          // Mode is latched only here, so a byte is never split across modes.
          man_d = man_en && MAN_OK;
          if (man_en && MAN_OK) begin
            word    = man_code[15 -: DATA_WIDTH];
            hold_d  = man_code[7:0];
            phase_d = PH_SECOND;
          end else begin
            word = data_in;
          end
        end
        serial_d = word[DATA_WIDTH-1];
        shreg_d  = word[DATA_WIDTH-2:0];
      end else begin
        serial_d = shreg_q[DATA_WIDTH-2];
        shreg_d  = shreg_q << 1;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      phase_q   <= PH_FIRST;
      bit_cnt_q <= CNT_LAST;
      shreg_q   <= '0;
      hold_q    <= '0;
      man_q     <= 1'b0;
      serial_q  <= IDLE_LEVEL;
    end else begin
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      hold_q    <= hold_d;
      man_q     <= man_d;
      serial_q  <= serial_d;
    end
  end

  // Handshake: word_req high means data_in is taken on the edge ending this cycle.
  assign word_req     = oce && load_edge && (phase_q == PH_FIRST);
  assign serial_out   = serial_q;
  assign serial_out_p = serial_q;
  assign serial_out_n = ~serial_q;

endmodule

// File: tb/tb_serial_tx_lane.sv
// Bench for serial_tx_lane: directed scenarios plus randomized traffic checked
// against a bit-queue model of the line.
module tb_serial_tx_lane;

  localparam int W = 8;

  logic         clk      = 1'b0;
  logic         aresetn  = 1'b0;
  logic         oce      = 1'b0;
  logic         man_en   = 1'b0;
  logic [W-1:0] data_in  = '0;
  logic         word_req;
  logic         serial_out;
  logic         serial_out_p;
  logic         serial_out_n;

  logic         exp_q[$];
  int           checks   = 0;
  int           failures = 0;
  logic [31:0]  line_log = '0;
  logic         last_bit = 1'b0;
  logic         pend_en  = 1'b0;

  serial_tx_lane #(.DATA_WIDTH(W), .IDLE_LEVEL(1'b0)) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .oce          (oce),
    .man_en       (man_en),
    .data_in      (data_in),
    .word_req     (word_req),
    .serial_out   (serial_out),
    .serial_out_p (serial_out_p),
    .serial_out_n (serial_out_n)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line bits a consumed word must produce, in transmission order.
  function automatic void push_word(input logic [W-1:0] d, input logic man);
    if (man) begin
      for (int i = W - 1; i >= 0; i--) begin
        exp_q.push_back(~d[i]);
        exp_q.push_back(d[i]);
      end
    end else begin
      for (int i = W - 1; i >= 0; i--) exp_q.push_back(d[i]);
    end
  endfunction

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      #3;
      chk("pn_pair", {30'd0, serial_out_p, serial_out_n}, {30'd0, serial_out, ~serial_out});
      if (!aresetn) begin
        exp_q.delete();
        last_bit = 1'b0;
        pend_en  = 1'b0;
        chk("reset_out", {31'd0, serial_out}, 32'd0);
      end
      chk("word_req", {31'd0, word_req}, {31'd0, oce && (exp_q.size() == 0)});
      if (aresetn) begin
        pend_en = oce;
        if (oce && exp_q.size() == 0) push_word(data_in, man_en);
      end
      @(posedge clk);
      #1;
      if (!aresetn) begin
        chk("reset_hold", {31'd0, serial_out}, 32'd0);
      end else if (pend_en) begin
        last_bit = exp_q.pop_front();
        chk("serial_bit", {31'd0, serial_out}, {31'd0, last_bit});
        line_log = {line_log[30:0], serial_out};
      end else begin
        chk("stall_hold", {31'd0, serial_out}, {31'd0, last_bit});
      end
    end
  end

  // driver tasks
  task automatic cyc(input logic rstn, input logic oce_v, input logic man_v, input logic [W-1:0] d);
    @(negedge clk);
    #1;
    aresetn = rstn;
    oce     = oce_v;
    man_en  = man_v;
    data_in = d;
  endtask

  task automatic do_reset();
    repeat (2) cyc(1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic log_check(input string name, input logic [31:0] mask, input logic [31:0] exp);
    @(negedge clk);
    #1;
    chk(name, line_log & mask, exp);
  endtask

  initial begin
    // Reset levels, then word_req in the first cycle after release.
    do_reset();
    #1;
    chk("rst_serial_out", {31'd0, serial_out}, 32'd0);
    chk("rst_p", {31'd0, serial_out_p}, 32'd0);
    chk("rst_n", {31'd0, serial_out_n}, 32'd1);
    cyc(1'b1, 1'b1, 1'b0, 8'hAA);
    #1;
    chk("release_word_req", {31'd0, word_req}, 32'd1);

    // Raw back-to-back words.
    do_reset();
    repeat (8) cyc(1'b1, 1'b1, 1'b0, 8'hAA);
    repeat (8) cyc(1'b1, 1'b1, 1'b0, 8'hD5);
    log_check("raw_line", 32'h0000_FFFF, 32'h0000_AAD5);

    // Manchester bytes.
    do_reset();
    repeat (16) cyc(1'b1, 1'b1, 1'b1, 8'hAA);
    repeat (16) cyc(1'b1, 1'b1, 1'b1, 8'hD5);
    log_check("man_line", 32'hFFFF_FFFF, 32'h6666_5999);

    // Stall after three bits, resume with data_in changing underneath.
    do_reset();
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 8'hF0);
    repeat (5) cyc(1'b1, 1'b0, 1'b0, 8'($urandom));
    #1;
    chk("stall_level", {31'd0, serial_out}, 32'd1);
    repeat (5) cyc(1'b1, 1'b1, 1'b0, 8'($urandom));
    log_check("stall_line", 32'h0000_00FF, 32'h0000_00F0);

    // Reset in the middle of a word.
    do_reset();
    repeat (4) cyc(1'b1, 1'b1, 1'b0, 8'hFF);
    cyc(1'b0, 1'b1, 1'b0, 8'hFF);
    #1;
    chk("midword_reset_out", {31'd0, serial_out}, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 8'hFF);
    repeat (8) cyc(1'b1, 1'b1, 1'b0, 8'h3C);
    log_check("after_reset_line", 32'h0000_00FF, 32'h0000_003C);

    // Mode drops during the second half of an encoded byte.
    do_reset();
    repeat (10) cyc(1'b1, 1'b1, 1'b1, 8'hAA);
    repeat (6) cyc(1'b1, 1'b1, 1'b0, 8'hAA);
    repeat (8) cyc(1'b1, 1'b1, 1'b0, 8'h5A);
    log_check("mode_switch_line", 32'h00FF_FFFF, 32'h0066_665A);

    // Randomized traffic with stalls, mode changes and sporadic resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)), 8'($urandom));
    end

    @(negedge clk);
    #4;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
